fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_perf_counters.sv | 43 ++++
 rtl/fetch_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS core
// Contents:
//   word_t     32-bit machine word
//   NOP_INSTR  bubble instruction (sll $0,$0,0)
//   if_id_t    IF/ID pipeline register {instr, pcplus4, valid}
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        word_t instr;
        word_t pcplus4;
        logic  valid;
    } if_id_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - saturating fetch-stage event counters
// Ports:
//   clk, reset_n       core clock, synchronous active-low reset
//   i_inc_fetch        an instruction was loaded into IF/ID this cycle
//   i_inc_stall        stall held the front end without a redirect
//   i_inc_flush        IF/ID loaded a bubble from flush or redirect
//   o_perf_fetch/stall/flush  32-bit counts, saturating at all-ones
module fetch_perf_counters
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  i_inc_fetch,
    input  logic  i_inc_stall,
    input  logic  i_inc_flush,
    output word_t o_perf_fetch,
    output word_t o_perf_stall,
    output word_t o_perf_flush
);

    localparam word_t SAT = 32'hFFFF_FFFF;

    word_t r_fetch;
    word_t r_stall;
    word_t r_flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch <= '0;
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (i_inc_fetch && (r_fetch != SAT)) r_fetch <= r_fetch + 32'd1;
            if (i_inc_stall && (r_stall != SAT)) r_stall <= r_stall + 32'd1;
            if (i_inc_flush && (r_flush != SAT)) r_flush <= r_flush + 32'd1;
        end
    end

    assign o_perf_fetch = r_fetch;
    assign o_perf_stall = r_stall;
    assign o_perf_flush = r_flush;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
// Optional feature macro: FETCH_PERF_EN (adds saturating perf counters;
// when undefined the perf_* ports are tied to zero).
// Ports:
//   clk, reset_n                  core clock, synchronous active-low reset
//   stall                         hold PC and IF/ID
//   flush                         load a bubble into IF/ID
//   redirect_valid/target         taken branch/jump; new PC (bits [1:0] dropped)
//   imem_addr / imem_rdata        instruction memory port (addr = pc_F)
//   pc_F                          current fetch PC
//   instr_D, pcplus4_D, valid_D   IF/ID register contents
//   perf_fetch/stall/flush        event counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pcplus4_D,
    output logic        valid_D,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    import mips_pkg::*;

    word_t  r_pc;
    if_id_t r_if_id;
    word_t  w_pcplus4;
    logic   w_bubble;
    logic   w_load;

    assign w_pcplus4 = r_pc + 32'd4;
    // A redirect squashes the wrong-path word being fetched this cycle.
    assign w_bubble  = flush | redirect_valid;
    assign w_load    = !w_bubble && !stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc    <= RESET_PC;
            r_if_id <= '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};
        end else begin
            // Redirect beats stall: the hazard unit keeps stall high while
            // the branch sits in MEM, yet the PC must still move.
            if (redirect_valid)
                r_pc <= {redirect_target[31:2], 2'b00};
            else if (!stall)
                r_pc <= w_pcplus4;

            if (w_bubble)
                r_if_id <= '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};
            else if (!stall)
                r_if_id <= '{instr: imem_rdata, pcplus4: w_pcplus4, valid: 1'b1};
        end
    end

    assign imem_addr = r_pc;
    assign pc_F      = r_pc;
    assign instr_D   = r_if_id.instr;
    assign pcplus4_D = r_if_id.pcplus4;
    assign valid_D   = r_if_id.valid;

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf_counters (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_inc_fetch  (w_load),
        .i_inc_stall  (stall && !redirect_valid),
        .i_inc_flush  (w_bubble),
        .o_perf_fetch (perf_fetch),
        .o_perf_stall (perf_stall),
        .o_perf_flush (perf_flush)
    );
`else
    assign perf_fetch = 32'h0;
    assign perf_stall = 32'h0;
    assign perf_flush = 32'h0;
`endif

endmodule
